// File: rtl/hdmi_island_scheduler.sv
// rtl/hdmi_island_scheduler.sv - HDMI data-island sequencer with packet arbitration and BCH ECC insertion
module hdmi_island_scheduler #(
    parameter int NUM_SRC     = 2,
    parameter int MAX_PACKETS = 2,
    parameter int MIN_CTRL    = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   island_ok,
    input  logic                   hsync,
    input  logic                   vsync,
    input  logic [NUM_SRC-1:0]     src_ready,
    input  logic [NUM_SRC-1:0]     src_header,
    input  logic [2*NUM_SRC-1:0]   src_sub0,
    input  logic [2*NUM_SRC-1:0]   src_sub1,
    input  logic [2*NUM_SRC-1:0]   src_sub2,
    input  logic [2*NUM_SRC-1:0]   src_sub3,
    output logic [4:0]             aux_slot,
    output logic                   ae,
    output logic [NUM_SRC-1:0]     enable,
    output logic [1:0]             period,
    output logic [3:0]             ch0,
    output logic [3:0]             ch1,
    output logic [3:0]             ch2,
    output logic                   busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_LEAD_GB, S_PACKET, S_TRAIL_GB, S_GAP
    } state_t;

    localparam logic [7:0] GAP_LAST = 8'(MIN_CTRL - 1);
    localparam logic [4:0] MAX_PKT  = 5'(MAX_PACKETS);

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [NUM_SRC-1:0]     grant_q, grant_d;
    logic [4:0]             pkt_q, pkt_d;
    logic [4:0]             aux_slot_q, aux_slot_d;
    logic                   ae_q, ae_d, busy_q, busy_d;
    logic [NUM_SRC-1:0]     enable_q, enable_d;
    logic [NUM_SRC-1:0]     first_rdy, other_rdy, other_pick;
    logic [1:0]             per_s0;

    // Stage 1 aligns the state-machine view with the sources' registered bits.
    logic [1:0]             p1_period_q;
    logic [4:0]             p1_slot_q;
    logic [NUM_SRC-1:0]     p1_grant_q;
    logic                   p1_hsync_q, p1_vsync_q;

    logic [7:0]             e_hdr_q, e_hdr_d, hdr_base, sub_base;
    logic [3:0][7:0]        e_sub_q, e_sub_d;
    logic                   hdr_sel, hdr_out;
    logic [3:0][1:0]        sub_sel, sub_out;

    logic [1:0]             period_q;
    logic [3:0]             ch0_q, ch0_d, ch1_q, ch1_d, ch2_q, ch2_d;

    function automatic logic [7:0] lfsr_step(input logic [7:0] e, input logic b);
        logic fb;
        fb = b ^ e[0];
        return (e >> 1) ^ (fb ? 8'h83 : 8'h00);
    endfunction

    // Lowest set bit wins: x & -x isolates it.
    assign first_rdy  = src_ready & (~src_ready + NUM_SRC'(1));
    assign other_rdy  = src_ready & ~grant_q;
    assign other_pick = other_rdy & (~other_rdy + NUM_SRC'(1));

    assign aux_slot = aux_slot_q;
    assign ae       = ae_q;
    assign enable   = enable_q;
    assign busy     = busy_q;
    assign period   = period_q;
    assign ch0      = ch0_q;
    assign ch1      = ch1_q;
    assign ch2      = ch2_q;

    // Island sequencing, arbitration and next-cycle request outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 8'd1;
        grant_d = grant_q;
        pkt_d   = pkt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = 8'd0;
                if (island_ok && |src_ready) state_d = S_PREAMBLE;
            end
            S_PREAMBLE: if (cnt_q == 8'd7) begin
                state_d = S_LEAD_GB;
                cnt_d   = 8'd0;
            end
            S_LEAD_GB: if (cnt_q == 8'd1) begin
                state_d = S_PACKET;
                cnt_d   = 8'd0;
                grant_d = first_rdy;
                pkt_d   = 5'd1;
            end
            S_PACKET: if (cnt_q == 8'd31) begin
                cnt_d = 8'd0;
                if (pkt_q < MAX_PKT && |other_rdy) begin
                    grant_d = other_pick;
                    pkt_d   = pkt_q + 5'd1;
                end else begin
                    state_d = S_TRAIL_GB;
                    grant_d = '0;
                end
            end
            S_TRAIL_GB: if (cnt_q == 8'd1) begin
                state_d = S_GAP;
                cnt_d   = 8'd0;
            end
            S_GAP: if (cnt_q == GAP_LAST) begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
        ae_d       = (state_d == S_PACKET);
        enable_d   = ae_d ? grant_d : '0;
        aux_slot_d = ae_d ? cnt_d[4:0] : 5'd0;
        busy_d     = (state_d != S_IDLE);
    end

    // Period code of the current state, before the two-stage delay.
    always_comb begin
        case (state_q)
            S_PREAMBLE:             per_s0 = 2'd1;
            S_LEAD_GB, S_TRAIL_GB:  per_s0 = 2'd2;
            S_PACKET:               per_s0 = 2'd3;
            default:                per_s0 = 2'd0;
        endcase
    end

    // Select the granted source's bits, run the ECC LFSRs and substitute parity in the tail slots.
    always_comb begin
        hdr_sel  = |(src_header & p1_grant_q);
        sub_sel  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (p1_grant_q[i]) begin
                sub_sel[0] = sub_sel[0] | src_sub0[2*i +: 2];
                sub_sel[1] = sub_sel[1] | src_sub1[2*i +: 2];
                sub_sel[2] = sub_sel[2] | src_sub2[2*i +: 2];
                sub_sel[3] = sub_sel[3] | src_sub3[2*i +: 2];
            end
        end
        hdr_base = (p1_slot_q == 5'd0) ? 8'h00 : e_hdr_q;
        hdr_out  = hdr_sel;
        e_hdr_d  = e_hdr_q;
        if (p1_period_q == 2'd3) begin
            if (p1_slot_q < 5'd24) begin
                e_hdr_d = lfsr_step(hdr_base, hdr_sel);
            end else begin
                e_hdr_d = hdr_base;
                hdr_out = hdr_base[p1_slot_q[2:0]];
            end
        end
        sub_base = 8'h00;
        sub_out  = sub_sel;
        e_sub_d  = e_sub_q;
        for (int k = 0; k < 4; k++) begin
            sub_base = (p1_slot_q == 5'd0) ? 8'h00 : e_sub_q[k];
            if (p1_period_q == 2'd3) begin
                if (p1_slot_q < 5'd28) begin
                    e_sub_d[k] = lfsr_step(lfsr_step(sub_base, sub_sel[k][0]), sub_sel[k][1]);
                end else begin
                    e_sub_d[k] = sub_base;
                    sub_out[k] = {sub_base[{p1_slot_q[1:0], 1'b1}], sub_base[{p1_slot_q[1:0], 1'b0}]};
                end
            end
        end
    end

    // Encoder words for the period carried by stage 1.
    always_comb begin
        ch0_d = {2'b00, p1_vsync_q, p1_hsync_q};
        ch1_d = 4'd0;
        ch2_d = 4'd0;
        if (p1_period_q == 2'd3) begin
            ch0_d = {p1_slot_q != 5'd0, hdr_out, p1_vsync_q, p1_hsync_q};
            ch1_d = {sub_out[3][0], sub_out[2][0], sub_out[1][0], sub_out[0][0]};
            ch2_d = {sub_out[3][1], sub_out[2][1], sub_out[1][1], sub_out[0][1]};
        end else if (p1_period_q == 2'd2) begin
            ch0_d = {2'b11, p1_vsync_q, p1_hsync_q};
        end
    end

    // Syncs ride the same two-stage delay as the payload and keep flowing through reset.
    always_ff @(posedge clk) begin
        p1_hsync_q <= hsync;
        p1_vsync_q <= vsync;
    end

    // State, request outputs, pipeline and ECC registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            grant_q     <= '0;
            pkt_q       <= 5'd0;
            aux_slot_q  <= 5'd0;
            ae_q        <= 1'b0;
            enable_q    <= '0;
            busy_q      <= 1'b0;
            p1_period_q <= 2'd0;
            p1_slot_q   <= 5'd0;
            p1_grant_q  <= '0;
            e_hdr_q     <= 8'h00;
            e_sub_q     <= '0;
            period_q    <= 2'd0;
            ch0_q       <= {2'b00, p1_vsync_q, p1_hsync_q};
            ch1_q       <= 4'd0;
            ch2_q       <= 4'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            pkt_q       <= pkt_d;
            aux_slot_q  <= aux_slot_d;
            ae_q        <= ae_d;
            enable_q    <= enable_d;
            busy_q      <= busy_d;
            p1_period_q <= per_s0;
            p1_slot_q   <= aux_slot_q;
            p1_grant_q  <= enable_q;
            e_hdr_q     <= e_hdr_d;
            e_sub_q     <= e_sub_d;
            period_q    <= p1_period_q;
            ch0_q       <= ch0_d;
            ch1_q       <= ch1_d;
            ch2_q       <= ch2_d;
        end
    end

endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// tb/tb_hdmi_island_scheduler.sv - directed self-checking bench for hdmi_island_scheduler
module tb_hdmi_island_scheduler;

    localparam int NS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, island_ok, hsync, vsync;

    logic [NS-1:0]   a_ready, a_header, a_en, b_ready, b_en;
    logic [2*NS-1:0] a_sub [4];
    logic [4:0]      a_aux, b_aux;
    logic            a_ae, a_busy, b_ae, b_busy;
    logic [1:0]      a_period, b_period;
    logic [3:0]      a_ch0, a_ch1, a_ch2, b_ch0, b_ch1, b_ch2;
    logic [NS-1:0]   zero_ns;
    logic [2*NS-1:0] zero_2ns;
    assign zero_ns  = '0;
    assign zero_2ns = '0;

    int a_req [NS];
    int a_srv [NS];
    int b_req [NS];
    int b_srv [NS];

    logic [31:0] hdr_tab [NS];
    logic [31:0] sev_tab [NS][4];
    logic [31:0] sod_tab [NS][4];

    logic [1:0] tr_per [128];
    logic [3:0] tr_ch0 [128];
    logic [3:0] tr_ch1 [128];
    logic [3:0] tr_ch2 [128];
    logic       tr_busy [128];
    logic       tr_ae [128];
    logic [1:0] tr_en [128];
    logic [4:0] tr_aux [128];

    int n_checks = 0;
    int n_errors = 0;

    hdmi_island_scheduler #(.NUM_SRC(NS), .MAX_PACKETS(2), .MIN_CTRL(12)) dut (
        .clk(clk), .reset(reset), .island_ok(island_ok), .hsync(hsync), .vsync(vsync),
        .src_ready(a_ready), .src_header(a_header),
        .src_sub0(a_sub[0]), .src_sub1(a_sub[1]), .src_sub2(a_sub[2]), .src_sub3(a_sub[3]),
        .aux_slot(a_aux), .ae(a_ae), .enable(a_en), .period(a_period),
        .ch0(a_ch0), .ch1(a_ch1), .ch2(a_ch2), .busy(a_busy)
    );

    hdmi_island_scheduler #(.NUM_SRC(NS), .MAX_PACKETS(1), .MIN_CTRL(12)) dut_one (
        .clk(clk), .reset(reset), .island_ok(island_ok), .hsync(hsync), .vsync(vsync),
        .src_ready(b_ready), .src_header(zero_ns),
        .src_sub0(zero_2ns), .src_sub1(zero_2ns), .src_sub2(zero_2ns), .src_sub3(zero_2ns),
        .aux_slot(b_aux), .ae(b_ae), .enable(b_en), .period(b_period),
        .ch0(b_ch0), .ch1(b_ch1), .ch2(b_ch2), .busy(b_busy)
    );

    always_comb begin
        for (int i = 0; i < NS; i++) begin
            a_ready[i] = (a_req[i] != a_srv[i]);
            b_ready[i] = (b_req[i] != b_srv[i]);
        end
    end

    // Source model: bits registered one clock after aux_slot; ready drops once the packet starts.
    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            a_header[i] <= hdr_tab[i][a_aux];
            for (int k = 0; k < 4; k++) begin
                a_sub[k][2*i]   <= sev_tab[i][k][a_aux];
                a_sub[k][2*i+1] <= sod_tab[i][k][a_aux];
            end
            if (a_en[i] && a_aux == 5'd0) a_srv[i] <= a_srv[i] + 1;
            if (b_en[i] && b_aux == 5'd0) b_srv[i] <= b_srv[i] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_busy(input string tag);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (a_busy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_start"}, 32'(ok), 32'h1);
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (a_busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_idle"}, 32'(ok), 32'h1);
    endtask

    task automatic capture(input int n);
        for (int k = 0; k < n; k++) begin
            tr_per[k]  = a_period;
            tr_ch0[k]  = a_ch0;
            tr_ch1[k]  = a_ch1;
            tr_ch2[k]  = a_ch2;
            tr_busy[k] = a_busy;
            tr_ae[k]   = a_ae;
            tr_en[k]   = a_en;
            tr_aux[k]  = a_aux;
            @(negedge clk);
        end
    endtask

    function automatic logic [1:0] exp_period(input int j, input int n);
        if (j < 8)           return 2'd1;
        if (j < 10)          return 2'd2;
        if (j < 10 + 32*n)   return 2'd3;
        if (j < 12 + 32*n)   return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [31:0] slot_vec(input int p, input int b, input int ch);
        logic [31:0] v;
        int k;
        v = '0;
        for (int s = 0; s < 32; s++) begin
            k = 12 + 32*p + s;
            case (ch)
                0:       v[s] = tr_ch0[k][b];
                1:       v[s] = tr_ch1[k][b];
                default: v[s] = tr_ch2[k][b];
            endcase
        end
        return v;
    endfunction

    task automatic check_island(input string tag, input int n);
        int bad, blen, aen;
        bad = 0; blen = 0; aen = 0;
        for (int k = 2; k < 16 + 32*n; k++)
            if (tr_per[k] !== exp_period(k - 2, n)) bad++;
        check({tag, "_period_seq"}, 32'(bad), 32'h0);
        while (blen < 128 && tr_busy[blen] === 1'b1) blen++;
        check({tag, "_busy_len"}, 32'(blen), 32'(24 + 32*n));
        for (int k = 0; k < 16 + 32*n; k++)
            if (tr_ae[k] === 1'b1) aen++;
        check({tag, "_ae_cycles"}, 32'(aen), 32'(32*n));
    endtask

    initial begin
        logic [31:0] acc;
        logic        h_old, h_new;
        bit          found, busy_seen, pre_seen;
        int          islands, gap, zeros, nen;
        int          len [2];
        logic [1:0]  en_seq [2];
        logic [1:0]  prev;

        reset = 1'b1; island_ok = 1'b0; hsync = 1'b0; vsync = 1'b0;
        for (int i = 0; i < NS; i++) begin
            a_req[i] = 0; b_req[i] = 0; hdr_tab[i] = '0;
            for (int k = 0; k < 4; k++) begin
                sev_tab[i][k] = '0;
                sod_tab[i][k] = '0;
            end
        end
        repeat (4) @(negedge clk);
        check("rst_period", 32'(a_period), 32'h0);
        check("rst_busy",   32'(a_busy),   32'h0);
        check("rst_ae_en",  32'({a_ae, a_en}), 32'h0);
        check("rst_aux",    32'(a_aux),    32'h0);
        check("rst_ch",     32'({a_ch0, a_ch1, a_ch2}), 32'h0);

        reset = 1'b0; hsync = 1'b1;
        repeat (3) @(negedge clk);
        check("ctrl_ch0", 32'(a_ch0), 32'h1);
        check("ctrl_ch12", 32'({a_ch1, a_ch2}), 32'h0);

        // Single packet from source 0, header 01 00 00.
        hdr_tab[0] = 32'h0000_0001;
        a_req[0]++;
        island_ok = 1'b1;
        wait_busy("t1");
        capture(64);
        check_island("t1", 1);
        check("t1_hdr_bits", slot_vec(0, 2, 0), 32'h4A00_0001);
        check("t1_ch0_b3",   slot_vec(0, 3, 0), 32'hFFFF_FFFE);
        acc = '0;
        for (int k = 12; k < 44; k++) acc = acc | 32'({tr_ch1[k], tr_ch2[k]});
        check("t1_sub_zero", acc, 32'h0);
        check("t1_grant",    32'(tr_en[10]), 32'h1);
        check("t1_pre_ch0",  32'(tr_ch0[2]),  32'h1);
        check("t1_gb_ch0",   32'(tr_ch0[10]), 32'hD);
        check("t1_trail_ch0", 32'(tr_ch0[44]), 32'hD);
        check("t1_ready_drop", 32'(a_ready[0]), 32'h0);

        // Both sources at once, two packets back to back.
        hdr_tab[0] = 32'h0;
        hdr_tab[1] = 32'h0000_0001;
        sev_tab[1][0] = 32'h0000_0001;
        a_req[0]++; a_req[1]++;
        wait_busy("t2");
        capture(100);
        check_island("t2", 2);
        check("t2_grant0", 32'(tr_en[10]), 32'h1);
        check("t2_grant1", 32'(tr_en[42]), 32'h2);
        check("t2_aux31",  32'(tr_aux[41]), 32'd31);
        check("t2_aux0",   32'(tr_aux[42]), 32'd0);
        check("t2_slot0_b3", 32'({tr_ch0[12][3], tr_ch0[44][3]}), 32'h0);
        check("t2_hdr_p0",  slot_vec(0, 2, 0), 32'h0);
        check("t2_hdr_p1",  slot_vec(1, 2, 0), 32'h4A00_0001);
        check("t2_sub0_ev_p0", slot_vec(0, 0, 1), 32'h0);
        check("t2_sub0_ev_p1", slot_vec(1, 0, 1), 32'h7000_0001);
        check("t2_sub0_od_p1", slot_vec(1, 0, 2), 32'hF000_0000);
        check("t2_sub1_p1",    slot_vec(1, 1, 1) | slot_vec(1, 1, 2), 32'h0);

        // One packet per island: two islands separated by the control gap.
        islands = 0; gap = 0; zeros = 0; nen = 0; prev = 2'd0;
        len[0] = 0; len[1] = 0; en_seq[0] = 2'd0; en_seq[1] = 2'd0;
        b_req[0]++; b_req[1]++;
        for (int t = 0; t < 220; t++) begin
            @(negedge clk);
            if (b_period != 2'd0) begin
                if (prev == 2'd0) begin
                    if (islands == 1) gap = zeros;
                    islands++;
                end
                if (islands >= 1 && islands <= 2) len[islands-1]++;
                zeros = 0;
            end else begin
                zeros++;
            end
            if (b_ae && b_aux == 5'd0 && nen < 2) begin
                en_seq[nen] = b_en;
                nen++;
            end
            prev = b_period;
        end
        check("t3_islands", 32'(islands), 32'd2);
        check("t3_len0", 32'(len[0]), 32'd44);
        check("t3_len1", 32'(len[1]), 32'd44);
        check("t3_gap_ge12", 32'(gap >= 12), 32'h1);
        check("t3_order", 32'({en_seq[0], en_seq[1]}), 32'b0110);

        // Slot 5 source bit and a same-cycle hsync toggle reach ch0 two clocks later.
        hdr_tab[0] = 32'h0000_0020;
        a_req[0]++;
        wait_busy("t4");
        found = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (a_ae && a_aux == 5'd5) begin
                found = 1'b1;
                break;
            end
        end
        check("t4_slot5_seen", 32'(found), 32'h1);
        h_old = hsync;
        hsync = ~hsync;
        h_new = hsync;
        @(negedge clk);
        check("t4_slot4_hdr",   32'(a_ch0[2]), 32'h0);
        check("t4_slot4_hsync", 32'(a_ch0[0]), 32'(h_old));
        @(negedge clk);
        check("t4_slot5_hdr",   32'(a_ch0[2]), 32'h1);
        check("t4_slot5_hsync", 32'(a_ch0[0]), 32'(h_new));
        wait_idle("t4");

        // Reset in the middle of a packet, then a clean restart.
        hdr_tab[0] = 32'h0000_0001;
        a_req[0]++;
        wait_busy("t5");
        found = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (a_ae && a_aux == 5'd10) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("t5_slot10_seen", 32'(found), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        check("t5_ae_en_off", 32'({a_ae, a_en}), 32'h0);
        check("t5_busy_off",  32'(a_busy), 32'h0);
        @(negedge clk);
        check("t5_period_off", 32'(a_period), 32'h0);
        reset = 1'b0;
        a_req[0]++;
        wait_busy("t5_restart");
        capture(64);
        check_island("t5", 1);
        check("t5_hdr_bits", slot_vec(0, 2, 0), 32'h4A00_0001);

        // Ready without island_ok never starts an island.
        island_ok = 1'b0;
        a_req[0]++;
        busy_seen = 1'b0; pre_seen = 1'b0;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (a_busy !== 1'b0) busy_seen = 1'b1;
            if (a_period !== 2'd0) pre_seen = 1'b1;
        end
        check("t6_no_busy", 32'(busy_seen), 32'h0);
        check("t6_no_preamble", 32'(pre_seen), 32'h0);
        island_ok = 1'b1;
        wait_busy("t6_release");
        wait_idle("t6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hdmi_island_scheduler.md
# hdmi_island_scheduler

Data-island scheduler and BCH ECC generator for the HDMI transmitter. It sits directly downstream of the aux packet sources (audio clock regeneration, audio sample, and later InfoFrames). It arbitrates between sources whose `ready` is high and drives `aux_slot`, `ae` and the per-source `enable` that those sources consume. It sequences preamble, guard bands and 32-clock packets, inserts header and subpacket ECC, and presents 4-bit per-channel words to the TERC4/TMDS encoder stage.

## Interface
- `NUM_SRC`, default 2: number of packet sources; index 0 has highest priority.
- `MAX_PACKETS`, default 2: maximum packets per island, range 1..18.
- `MIN_CTRL`, default 12: minimum control-period clocks after an island before the next preamble.
- `clk`  in  1: pixel clock, the only clock.
- `reset`  in  1: synchronous, active-high.
- `island_ok`  in  1: video timing says an island of `MAX_PACKETS` packets fits starting now. Sampled in IDLE only.
- `hsync`, `vsync`  in  1 each: raw syncs, carried into channel 0.
- `src_ready`  in  NUM_SRC: source needs sending.
- `src_header`  in  NUM_SRC: header bit per source, registered by the source one clock after `aux_slot`.
- `src_sub0`..`src_sub3`  in  2*NUM_SRC each: subpacket bit pairs per source, same one-clock lag.
- `aux_slot`  out  5: slot being requested from the sources.
- `ae`  out  1: high during every packet-payload request cycle.
- `enable`  out  NUM_SRC: one-hot grant, held for the whole packet.
- `period`  out  2: 0 control, 1 data preamble, 2 data guard band, 3 data payload.
- `ch0`, `ch1`, `ch2`  out  4 each: words for the encoder.
- `busy`  out  1: high from PREAMBLE entry until GAP exit.

## Operation
- States: IDLE, PREAMBLE (8 clk), LEAD_GB (2), PACKET (32, slot counter s=0..31), TRAIL_GB (2), GAP (`MIN_CTRL`).
- IDLE to PREAMBLE when `island_ok` and any `src_ready` is high.
- Last LEAD_GB cycle: the grant is latched to the lowest-index ready source, and the packet count is set to 1.
- PACKET s=31:
  - If the packet count is below `MAX_PACKETS` and any source other than the current one is ready, grant the lowest such index, increment the count, and go to PACKET s=0.
  - Otherwise go to TRAIL_GB.
- GAP then IDLE.
- During PACKET: `aux_slot`=s, `ae`=1, `enable`=grant. At all other times `aux_slot`=0, `ae`=0, `enable`=0.
- ECC uses the LFSR step `fb=bit^e[0]; e=(e>>1)^(fb?8'h83:0)`, with e cleared at s=0.
- Header: slots 0..23 feed the header LFSR. Slots 24..31 output `e[s-24]` instead of the source bit.
- Subpacket k: each clock steps the even bit, then the odd bit. Slots 0..27 feed the LFSR. Slots 28..31 output `{e[2(s-28)+1], e[2(s-28)]}`; the source bits there are ignored.
- Payload words:
  - `ch0`={s!=0, hdr, vsync, hsync}
  - `ch1`={sub3[0], sub2[0], sub1[0], sub0[0]}
  - `ch2`={sub3[1], sub2[1], sub1[1], sub0[1]}
- Guard band: `ch0`={2'b11, vsync, hsync}, and `ch1`=`ch2`=0.
- Control and preamble: `ch0`={2'b00, vsync, hsync}, and `ch1`=`ch2`=0.

## Timing
- `period`, `ch0`..`ch2` and the hsync/vsync values they carry lag the state machine by exactly 2 clocks:
  - 1 clock for the source register;
  - 1 clock for the output register.
- `aux_slot`, `ae`, `enable` and `busy` are not delayed.
- Island length is 8+2+32·n+2 clocks of `period`≠0.
- `ae` and `enable` are high together from the first PACKET cycle, so the granted source drops `src_ready` one clock later. Re-triggering mid-packet is not dropped: a source re-asserting `src_ready` is re-evaluated at the next arbitration point.
- Simultaneous ready sources: the lowest index wins. The remaining sources are served in the same island if count allows, otherwise in the next island.
- `island_ok` deasserting after PREAMBLE entry does not abort the island.
- Reset values: state IDLE; all outputs 0 except `ch0`={00, vsync, hsync} after 2 clocks. The delay line is cleared to `period`=0.
- Reset mid-island: returns to IDLE on the next edge. `enable`/`ae` are 0 at once; `period` returns to 0 within 2 clocks. The GAP is skipped.

## Test plan
- Source 0 ready, header 01 00 00, all subpackets 0:
  - `period` sequence is 1×8, 2×2, 3×32, 2×2, then 0.
  - Header slots 24..31 carry 0x4A LSB-first.
  - All subpacket ECC bits are 0.
- Both sources ready at once, `MAX_PACKETS`=2:
  - Source 0 is granted first, then source 1 back to back with no guard band between them.
  - `ch0[3]` is 0 at each packet's slot 0.
- Both ready, `MAX_PACKETS`=1:
  - Two islands.
  - The second preamble starts no earlier than 12 clocks of `period`=0 after the first trailing guard band.
- `aux_slot`=5 request cycle vs. `ch` output: the source bit for slot 5 appears on `ch0[2]` exactly 2 clocks later. `hsync` toggled at the same cycle appears in `ch0[0]` in that same output cycle.
- `reset` asserted at PACKET s=10:
  - `ae` and `enable` are 0 the next clock.
  - `period` is 0 after 2 clocks.
  - A new island starts cleanly after release when `island_ok` and a source are ready.
- `src_ready` without `island_ok` for 1000 clocks: no preamble, `busy`=0.
